// File: rtl/mem_arbiter.sv
// Main-memory arbiter for the I-cache and D-cache miss paths.
// Tags reads with IDs and routes out-of-order line responses to their owner.
module mem_arbiter #(
    parameter int PA_WIDTH   = 32,
    parameter int REG_WIDTH  = 32,
    parameter int LINE_WIDTH = 128,
    parameter int ID_WIDTH   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_ic_req,
    input  logic [PA_WIDTH-1:0]   i_ic_addr,
    output logic                  o_ic_grant,
    output logic                  o_ic_resp_valid,
    output logic [LINE_WIDTH-1:0] o_ic_resp_data,
    input  logic                  i_dc_req,
    input  logic                  i_dc_write,
    input  logic [PA_WIDTH-1:0]   i_dc_addr,
    input  logic [REG_WIDTH-1:0]  i_dc_data,
    output logic                  o_dc_grant,
    output logic                  o_dc_resp_valid,
    output logic [LINE_WIDTH-1:0] o_dc_resp_data,
    output logic                  o_mem_enable,
    output logic                  o_mem_write,
    output logic [PA_WIDTH-1:0]   o_mem_addr,
    output logic [REG_WIDTH-1:0]  o_mem_data,
    output logic [ID_WIDTH-1:0]   o_mem_id,
    input  logic                  i_mem_ready,
    input  logic                  i_mem_valid,
    input  logic [ID_WIDTH-1:0]   i_mem_id,
    input  logic [LINE_WIDTH-1:0] i_mem_data,
    output logic                  o_mem_ack,
    output logic                  o_err
);
    localparam int NID = 1 << ID_WIDTH;

    // Issue register
    logic                  iss_valid_q, iss_valid_d;
    logic                  iss_write_q, iss_write_d;
    logic [PA_WIDTH-1:0]   iss_addr_q, iss_addr_d;
    logic [REG_WIDTH-1:0]  iss_data_q, iss_data_d;
    logic [ID_WIDTH-1:0]   iss_id_q, iss_id_d;

    // Owner table: owner bit 0 = port I, 1 = port D
    logic [NID-1:0]        busy_q, busy_d;
    logic [NID-1:0]        owner_q, owner_d;

    // Round-robin pointer: 0 = port I has priority, 1 = port D
    logic                  rr_q, rr_d;

    // Registered response stage
    logic                  ack_q;
    logic                  ic_rv_q, dc_rv_q;
    logic [LINE_WIDTH-1:0] ic_rdata_q, dc_rdata_q;
    logic                  rel_q;
    logic [ID_WIDTH-1:0]   rel_id_q;
    logic                  err_q;

    logic                  id_avail;
    logic [ID_WIDTH-1:0]   free_id;
    logic                  iss_free;
    logic                  ic_elig, dc_elig;
    logic                  ic_gnt, dc_gnt, rd_gnt;
    logic                  rsp_hit, rsp_own;

    // Lowest free transaction ID
    always_comb begin
        id_avail = 1'b0;
        free_id  = '0;
        for (int i = NID - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                id_avail = 1'b1;
                free_id  = ID_WIDTH'(i);
            end
        end
    end

    // Eligibility and round-robin grant
    always_comb begin
        iss_free = !iss_valid_q || i_mem_ready;
        ic_elig  = !rst && i_ic_req && iss_free && id_avail;
        dc_elig  = !rst && i_dc_req && iss_free && (i_dc_write || id_avail);
        ic_gnt   = ic_elig && (!dc_elig || !rr_q);
        dc_gnt   = dc_elig && (!ic_elig || rr_q);
        rd_gnt   = ic_gnt || (dc_gnt && !i_dc_write);
        rr_d     = (ic_elig && dc_elig) ? !rr_q : rr_q;
        rsp_hit  = i_mem_valid && busy_q[i_mem_id];
        rsp_own  = owner_q[i_mem_id];
    end

    // Issue register and owner table next state
    always_comb begin
        iss_valid_d = iss_valid_q;
        iss_write_d = iss_write_q;
        iss_addr_d  = iss_addr_q;
        iss_data_d  = iss_data_q;
        iss_id_d    = iss_id_q;
        busy_d      = busy_q;
        owner_d     = owner_q;
        if (ic_gnt || dc_gnt) begin
            iss_valid_d = 1'b1;
            iss_write_d = dc_gnt && i_dc_write;
            iss_addr_d  = dc_gnt ? i_dc_addr : i_ic_addr;
            iss_data_d  = (dc_gnt && i_dc_write) ? i_dc_data : '0;
            iss_id_d    = (dc_gnt && i_dc_write) ? '0 : free_id;
        end else if (i_mem_ready) begin
            iss_valid_d = 1'b0;
        end
        if (rel_q) begin
            busy_d[rel_id_q] = 1'b0;
        end
        if (rd_gnt) begin
            busy_d[free_id]  = 1'b1;
            owner_d[free_id] = dc_gnt;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            iss_valid_q <= 1'b0;
            iss_write_q <= 1'b0;
            iss_addr_q  <= '0;
            iss_data_q  <= '0;
            iss_id_q    <= '0;
            busy_q      <= '0;
            owner_q     <= '0;
            rr_q        <= 1'b0;
            ack_q       <= 1'b0;
            ic_rv_q     <= 1'b0;
            dc_rv_q     <= 1'b0;
            ic_rdata_q  <= '0;
            dc_rdata_q  <= '0;
            rel_q       <= 1'b0;
            rel_id_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            iss_valid_q <= iss_valid_d;
            iss_write_q <= iss_write_d;
            iss_addr_q  <= iss_addr_d;
            iss_data_q  <= iss_data_d;
            iss_id_q    <= iss_id_d;
            busy_q      <= busy_d;
            owner_q     <= owner_d;
            rr_q        <= rr_d;
            ack_q       <= i_mem_valid;
            ic_rv_q     <= rsp_hit && !rsp_own;
            dc_rv_q     <= rsp_hit && rsp_own;
            if (rsp_hit && !rsp_own) begin
                ic_rdata_q <= i_mem_data;
            end
            if (rsp_hit && rsp_own) begin
                dc_rdata_q <= i_mem_data;
            end
            rel_q       <= rsp_hit;
            rel_id_q    <= i_mem_id;
            err_q       <= err_q || (i_mem_valid && !rsp_hit);
        end
    end

    // Output wiring
    always_comb begin
        o_ic_grant      = ic_gnt;
        o_dc_grant      = dc_gnt;
        o_mem_enable    = iss_valid_q;
        o_mem_write     = iss_write_q;
        o_mem_addr      = iss_addr_q;
        o_mem_data      = iss_data_q;
        o_mem_id        = iss_id_q;
        o_mem_ack       = ack_q;
        o_ic_resp_valid = ic_rv_q;
        o_ic_resp_data  = ic_rdata_q;
        o_dc_resp_valid = dc_rv_q;
        o_dc_resp_data  = dc_rdata_q;
        o_err           = err_q;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed table-driven bench for mem_arbiter.
// Each table row is one clock cycle of inputs and expected outputs.
module tb_mem_arbiter;
    logic         clk = 1'b0;
    logic         rst;
    logic         i_ic_req;
    logic [31:0]  i_ic_addr;
    logic         o_ic_grant;
    logic         o_ic_resp_valid;
    logic [127:0] o_ic_resp_data;
    logic         i_dc_req;
    logic         i_dc_write;
    logic [31:0]  i_dc_addr;
    logic [31:0]  i_dc_data;
    logic         o_dc_grant;
    logic         o_dc_resp_valid;
    logic [127:0] o_dc_resp_data;
    logic         o_mem_enable;
    logic         o_mem_write;
    logic [31:0]  o_mem_addr;
    logic [31:0]  o_mem_data;
    logic [1:0]   o_mem_id;
    logic         i_mem_ready;
    logic         i_mem_valid;
    logic [1:0]   i_mem_id;
    logic [127:0] i_mem_data;
    logic         o_mem_ack;
    logic         o_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .i_ic_req(i_ic_req), .i_ic_addr(i_ic_addr),
        .o_ic_grant(o_ic_grant),
        .o_ic_resp_valid(o_ic_resp_valid),
        .o_ic_resp_data(o_ic_resp_data),
        .i_dc_req(i_dc_req), .i_dc_write(i_dc_write),
        .i_dc_addr(i_dc_addr), .i_dc_data(i_dc_data),
        .o_dc_grant(o_dc_grant),
        .o_dc_resp_valid(o_dc_resp_valid),
        .o_dc_resp_data(o_dc_resp_data),
        .o_mem_enable(o_mem_enable), .o_mem_write(o_mem_write),
        .o_mem_addr(o_mem_addr), .o_mem_data(o_mem_data),
        .o_mem_id(o_mem_id), .i_mem_ready(i_mem_ready),
        .i_mem_valid(i_mem_valid), .i_mem_id(i_mem_id),
        .i_mem_data(i_mem_data), .o_mem_ack(o_mem_ack),
        .o_err(o_err)
    );

    typedef struct {
        int unsigned icr, ica, dcr, dw, dca, dcd;
        int unsigned rdy, mv, mid, mb;
        int unsigned icg, dcg, en, wr, addr, wd, id;
        int unsigned icrv, dcrv, rb, ack, err;
    } vec_t;

    vec_t tv[$];

    task automatic chk(input int idx, input string nm,
                       input logic [31:0] act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL v%0d %s got %0h want %0h", idx, nm, act, exp);
        end
    endtask

    task automatic chkd(input int idx, input string nm,
                        input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL v%0d %s got %0h want %0h", idx, nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        i_ic_req    = v.icr[0];
        i_ic_addr   = v.ica;
        i_dc_req    = v.dcr[0];
        i_dc_write  = v.dw[0];
        i_dc_addr   = v.dca;
        i_dc_data   = v.dcd;
        i_mem_ready = v.rdy[0];
        i_mem_valid = v.mv[0];
        i_mem_id    = v.mid[1:0];
        i_mem_data  = {16{v.mb[7:0]}};
    endtask

    task automatic compare(input int k, input vec_t v);
        chk(k, "ic_grant", 32'(o_ic_grant), v.icg);
        chk(k, "dc_grant", 32'(o_dc_grant), v.dcg);
        chk(k, "mem_enable", 32'(o_mem_enable), v.en);
        if (v.en != 0) begin
            chk(k, "mem_write", 32'(o_mem_write), v.wr);
            chk(k, "mem_addr", o_mem_addr, v.addr);
            chk(k, "mem_id", 32'(o_mem_id), v.id);
            if (v.wr != 0) chk(k, "mem_data", o_mem_data, v.wd);
        end
        chk(k, "ic_resp_valid", 32'(o_ic_resp_valid), v.icrv);
        chk(k, "dc_resp_valid", 32'(o_dc_resp_valid), v.dcrv);
        if (v.icrv != 0)
            chkd(k, "ic_resp_data", o_ic_resp_data, {16{v.rb[7:0]}});
        if (v.dcrv != 0)
            chkd(k, "dc_resp_data", o_dc_resp_data, {16{v.rb[7:0]}});
        chk(k, "mem_ack", 32'(o_mem_ack), v.ack);
        chk(k, "err", 32'(o_err), v.err);
    endtask

    task automatic quiet(input int k);
        chk(k, "q_ic_grant", 32'(o_ic_grant), 0);
        chk(k, "q_dc_grant", 32'(o_dc_grant), 0);
        chk(k, "q_mem_enable", 32'(o_mem_enable), 0);
        chk(k, "q_mem_write", 32'(o_mem_write), 0);
        chk(k, "q_mem_addr", o_mem_addr, 0);
        chk(k, "q_mem_data", o_mem_data, 0);
        chk(k, "q_mem_id", 32'(o_mem_id), 0);
        chk(k, "q_ic_rv", 32'(o_ic_resp_valid), 0);
        chk(k, "q_dc_rv", 32'(o_dc_resp_valid), 0);
        chkd(k, "q_ic_data", o_ic_resp_data, '0);
        chkd(k, "q_dc_data", o_dc_resp_data, '0);
        chk(k, "q_mem_ack", 32'(o_mem_ack), 0);
        chk(k, "q_err", 32'(o_err), 0);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t idle;
        idle = '{0,0,0,0,0,0, 1,0,0,0, 0,0,0,0,0,0,0, 0,0,0,0,0};

        // single read, response routed to I
        tv.push_back('{1,'h100,0,0,0,0, 1,0,0,0, 1,0,0,0,0,0,0, 0,0,0,0,0});
        tv.push_back('{0,0,0,0,0,0, 1,0,0,0, 0,0,1,0,'h100,0,0, 0,0,0,0,0});
        tv.push_back('{0,0,0,0,0,0, 1,1,0,'hAA, 0,0,0,0,0,0,0, 0,0,0,0,0});
        tv.push_back('{0,0,0,0,0,0, 1,0,0,0, 0,0,0,0,0,0,0, 1,0,'hAA,1,0});
        tv.push_back(idle);
        // contention: I,D,I,D with IDs 0..3, then IDs exhausted
        tv.push_back('{1,'h200,1,0,'h300,0, 1,0,0,0, 1,0,0,0,0,0,0, 0,0,0,0,0});
        tv.push_back('{1,'h200,1,0,'h300,0, 1,0,0,0, 0,1,1,0,'h200,0,0, 0,0,0,0,0});
        tv.push_back('{1,'h200,1,0,'h300,0, 1,0,0,0, 1,0,1,0,'h300,0,1, 0,0,0,0,0});
        tv.push_back('{1,'h200,1,0,'h300,0, 1,0,0,0, 0,1,1,0,'h200,0,2, 0,0,0,0,0});
        tv.push_back('{1,'h200,1,0,'h300,0, 1,0,0,0, 0,0,1,0,'h300,0,3, 0,0,0,0,0});
        // write granted while all IDs busy; read still blocked
        tv.push_back('{1,'h200,1,1,'h400,'h12345678, 1,0,0,0, 0,1,0,0,0,0,0, 0,0,0,0,0});
        tv.push_back('{1,'h200,0,0,0,0, 1,1,2,'h22, 0,0,1,1,'h400,'h12345678,0, 0,0,0,0,0});
        tv.push_back('{1,'h200,0,0,0,0, 1,0,0,0, 0,0,0,0,0,0,0, 1,0,'h22,1,0});
        tv.push_back('{1,'h200,0,0,0,0, 1,0,0,0, 1,0,0,0,0,0,0, 0,0,0,0,0});
        // drain all IDs back to their owners
        tv.push_back('{0,0,0,0,0,0, 1,1,0,'h30, 0,0,1,0,'h200,0,2, 0,0,0,0,0});
        tv.push_back('{0,0,0,0,0,0, 1,1,1,'h31, 0,0,0,0,0,0,0, 1,0,'h30,1,0});
        tv.push_back('{0,0,0,0,0,0, 1,1,3,'h33, 0,0,0,0,0,0,0, 0,1,'h31,1,0});
        tv.push_back('{0,0,0,0,0,0, 1,1,2,'h32, 0,0,0,0,0,0,0, 0,1,'h33,1,0});
        tv.push_back('{0,0,0,0,0,0, 1,0,0,0, 0,0,0,0,0,0,0, 1,0,'h32,1,0});
        // backpressure
        tv.push_back('{0,0,1,1,'h600,'hCAFE0001, 0,0,0,0, 0,1,0,0,0,0,0, 0,0,0,0,0});
        tv.push_back('{1,'h700,1,1,'h604,'hCAFE0002, 0,0,0,0, 0,0,1,1,'h600,'hCAFE0001,0, 0,0,0,0,0});
        tv.push_back('{1,'h700,1,1,'h604,'hCAFE0002, 0,0,0,0, 0,0,1,1,'h600,'hCAFE0001,0, 0,0,0,0,0});
        tv.push_back('{1,'h700,1,1,'h604,'hCAFE0002, 0,0,0,0, 0,0,1,1,'h600,'hCAFE0001,0, 0,0,0,0,0});
        tv.push_back('{1,'h700,1,1,'h604,'hCAFE0002, 1,0,0,0, 1,0,1,1,'h600,'hCAFE0001,0, 0,0,0,0,0});
        tv.push_back('{0,0,1,1,'h604,'hCAFE0002, 1,0,0,0, 0,1,1,0,'h700,0,0, 0,0,0,0,0});
        tv.push_back('{0,0,0,0,0,0, 1,0,0,0, 0,0,1,1,'h604,'hCAFE0002,0, 0,0,0,0,0});
        tv.push_back('{0,0,0,0,0,0, 1,1,0,'h40, 0,0,0,0,0,0,0, 0,0,0,0,0});
        tv.push_back('{0,0,0,0,0,0, 1,0,0,0, 0,0,0,0,0,0,0, 1,0,'h40,1,0});
        // out-of-order: D gets id 0, I gets id 1, respond 1 then 0
        tv.push_back('{1,'h900,1,0,'h800,0, 1,0,0,0, 0,1,0,0,0,0,0, 0,0,0,0,0});
        tv.push_back('{1,'h900,0,0,0,0, 1,0,0,0, 1,0,1,0,'h800,0,0, 0,0,0,0,0});
        tv.push_back('{0,0,0,0,0,0, 1,0,0,0, 0,0,1,0,'h900,0,1, 0,0,0,0,0});
        tv.push_back('{0,0,0,0,0,0, 1,1,1,'h51, 0,0,0,0,0,0,0, 0,0,0,0,0});
        tv.push_back('{0,0,0,0,0,0, 1,1,0,'h50, 0,0,0,0,0,0,0, 1,0,'h51,1,0});
        tv.push_back('{0,0,0,0,0,0, 1,0,0,0, 0,0,0,0,0,0,0, 0,1,'h50,1,0});
        // spurious response on idle id 3
        tv.push_back('{0,0,0,0,0,0, 1,1,3,'h77, 0,0,0,0,0,0,0, 0,0,0,0,0});
        tv.push_back('{0,0,0,0,0,0, 1,0,0,0, 0,0,0,0,0,0,0, 0,0,0,1,1});
        tv.push_back('{0,0,0,0,0,0, 1,0,0,0, 0,0,0,0,0,0,0, 0,0,0,0,1});

        // reset state, grants suppressed while in reset
        rst = 1'b1;
        drive(idle);
        i_ic_req = 1'b1;
        i_dc_req = 1'b1;
        tick();
        tick();
        @(negedge clk);
        quiet(-1);
        tick();
        rst = 1'b0;

        for (int k = 0; k < tv.size(); k++) begin
            drive(tv[k]);
            @(negedge clk);
            compare(k, tv[k]);
            tick();
        end

        // reset clears sticky error
        drive(idle);
        rst = 1'b1;
        i_ic_req = 1'b1;
        tick();
        @(negedge clk);
        quiet(100);
        tick();

        // reset mid-transaction discards the outstanding read
        rst = 1'b0;
        i_ic_req = 1'b1;
        i_ic_addr = 32'hA00;
        i_mem_ready = 1'b0;
        @(negedge clk);
        chk(101, "mid_grant", 32'(o_ic_grant), 1);
        tick();
        i_ic_req = 1'b0;
        @(negedge clk);
        chk(102, "mid_enable", 32'(o_mem_enable), 1);
        chk(102, "mid_addr", o_mem_addr, 'hA00);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        i_mem_valid = 1'b1;
        i_mem_id = 2'd0;
        i_mem_data = {16{8'h99}};
        @(negedge clk);
        chk(103, "mid_cleared", 32'(o_mem_enable), 0);
        tick();
        i_mem_valid = 1'b0;
        @(negedge clk);
        chk(104, "mid_ack", 32'(o_mem_ack), 1);
        chk(104, "mid_ic_rv", 32'(o_ic_resp_valid), 0);
        chk(104, "mid_dc_rv", 32'(o_dc_resp_valid), 0);
        chk(104, "mid_err", 32'(o_err), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
